// File: rtl/cipher_uart_tx_if.sv
// Encryptor-side bundle for cipher_uart_tx: write strobe, data and completion in,
// serial line and status out.
interface cipher_uart_tx_if #(
   parameter int DEPTH_LOG2 = 4
);
   logic                  cipher_w_en;
   logic [7:0]            cipher_data;
   logic                  finished;
   logic                  tx;
   logic                  busy;
   logic                  done;
   logic                  overflow;
   logic [DEPTH_LOG2:0]   fifo_count;

   modport master (
      output cipher_w_en, cipher_data, finished,
      input  tx, busy, done, overflow, fifo_count
   );

   modport slave (
      input  cipher_w_en, cipher_data, finished,
      output tx, busy, done, overflow, fifo_count
   );
endinterface

// File: rtl/cipher_uart_tx.sv
// cipher_uart_tx: queues encryptor cipher bytes in a FIFO and sends them as UART frames.
// Optional macro CIPHER_TX_PARITY_EN adds an even parity bit (8E1); default framing is 8N1.
module cipher_uart_tx #(
   parameter int CLKS_PER_BIT = 868,
   parameter int DEPTH_LOG2   = 4
) (
   input  logic            clk,
   input  logic            rst,
   cipher_uart_tx_if.slave bus
);

   localparam int BAUD_W = $clog2(CLKS_PER_BIT);
   localparam int CNT_W  = DEPTH_LOG2 + 1;
   localparam logic [BAUD_W-1:0]     BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
   localparam logic [BAUD_W-1:0]     BAUD_ZERO = {BAUD_W{1'b0}};
   localparam logic [BAUD_W-1:0]     BAUD_ONE  = BAUD_W'(1);
   localparam logic [CNT_W-1:0]      CNT_ZERO  = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0]      CNT_ONE   = CNT_W'(1);
   localparam logic [CNT_W-1:0]      CNT_FULL  = CNT_W'(2 ** DEPTH_LOG2);
   localparam logic [DEPTH_LOG2-1:0] PTR_ONE   = DEPTH_LOG2'(1);

`ifdef CIPHER_TX_PARITY_EN
   typedef enum logic [2:0] {
      S_IDLE = 3'd0, S_START = 3'd1, S_DATA = 3'd2, S_PARITY = 3'd3, S_STOP = 3'd4
   } state_t;
`else
   typedef enum logic [2:0] {
      S_IDLE = 3'd0, S_START = 3'd1, S_DATA = 3'd2, S_STOP = 3'd4
   } state_t;
`endif

   function automatic logic even_parity(input logic [7:0] data);
      return ^data;
   endfunction

   logic [7:0]            mem_r [2**DEPTH_LOG2];
   logic [DEPTH_LOG2-1:0] wr_ptr_r;
   logic [DEPTH_LOG2-1:0] rd_ptr_r;
   logic [CNT_W-1:0]      count_r;
   logic                  push_s;
   logic                  pop_s;
   logic                  full_s;
   logic                  nonempty_s;
   logic [7:0]            head_s;

   state_t                state_r;
   state_t                state_s;
   logic [BAUD_W-1:0]     baud_r;
   logic [BAUD_W-1:0]     baud_s;
   logic                  baud_last_s;
   logic [2:0]            bit_r;
   logic [2:0]            bit_s;
   logic [7:0]            shift_r;
   logic [7:0]            shift_s;
   logic                  tx_r;
   logic                  tx_s;
   logic                  done_r;
   logic                  overflow_r;
   logic                  seen_r;
`ifdef CIPHER_TX_PARITY_EN
   logic                  par_r;
   logic                  par_s;
`endif

   assign full_s      = (count_r == CNT_FULL);
   assign nonempty_s  = (count_r != CNT_ZERO);
   assign head_s      = mem_r[rd_ptr_r];
   assign baud_last_s = (baud_r == BAUD_LAST);
   // A full FIFO still accepts a byte when the FSM frees a slot in the same cycle.
   assign push_s      = bus.cipher_w_en & (~full_s | pop_s);

   // FIFO storage; entries are only read when occupancy says they were written.
   always_ff @(posedge clk) begin
      if (push_s) begin
         mem_r[wr_ptr_r] <= bus.cipher_data;
      end
   end

   // FIFO pointers, occupancy and the sticky drop flag.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_r   <= {DEPTH_LOG2{1'b0}};
         rd_ptr_r   <= {DEPTH_LOG2{1'b0}};
         count_r    <= CNT_ZERO;
         overflow_r <= 1'b0;
      end else begin
         if (push_s) wr_ptr_r <= wr_ptr_r + PTR_ONE;
         if (pop_s)  rd_ptr_r <= rd_ptr_r + PTR_ONE;
         case ({push_s, pop_s})
            2'b10:   count_r <= count_r + CNT_ONE;
            2'b01:   count_r <= count_r - CNT_ONE;
            default: count_r <= count_r;
         endcase
         if (bus.cipher_w_en && full_s && !pop_s) overflow_r <= 1'b1;
      end
   end

   // Frame sequencer; tx is derived from the next state so it changes on the entry edge.
   always_comb begin
      state_s = state_r;
      baud_s  = baud_r;
      bit_s   = bit_r;
      shift_s = shift_r;
      pop_s   = 1'b0;
      tx_s    = 1'b1;
`ifdef CIPHER_TX_PARITY_EN
      par_s   = par_r;
`endif
      case (state_r)
         S_IDLE: begin
            if (nonempty_s) begin
               pop_s   = 1'b1;
               shift_s = head_s;
               bit_s   = 3'd0;
               baud_s  = BAUD_ZERO;
               state_s = S_START;
`ifdef CIPHER_TX_PARITY_EN
               par_s   = even_parity(head_s);
`endif
            end else begin
               state_s = S_IDLE;
            end
         end
         S_START: begin
            if (baud_last_s) begin
               baud_s  = BAUD_ZERO;
               state_s = S_DATA;
            end else begin
               baud_s  = baud_r + BAUD_ONE;
            end
         end
         S_DATA: begin
            if (baud_last_s) begin
               baud_s  = BAUD_ZERO;
               shift_s = {1'b0, shift_r[7:1]};
               if (bit_r == 3'd7) begin
`ifdef CIPHER_TX_PARITY_EN
                  state_s = S_PARITY;
`else
                  state_s = S_STOP;
`endif
               end else begin
                  bit_s = bit_r + 3'd1;
               end
            end else begin
               baud_s  = baud_r + BAUD_ONE;
            end
         end
`ifdef CIPHER_TX_PARITY_EN
         S_PARITY: begin
            if (baud_last_s) begin
               baud_s  = BAUD_ZERO;
               state_s = S_STOP;
            end else begin
               baud_s  = baud_r + BAUD_ONE;
            end
         end
`endif
         S_STOP: begin
            if (baud_last_s) begin
               baud_s = BAUD_ZERO;
               if (nonempty_s) begin
                  pop_s   = 1'b1;
                  shift_s = head_s;
                  bit_s   = 3'd0;
                  state_s = S_START;
`ifdef CIPHER_TX_PARITY_EN
                  par_s   = even_parity(head_s);
`endif
               end else begin
                  state_s = S_IDLE;
               end
            end else begin
               baud_s = baud_r + BAUD_ONE;
            end
         end
         default: state_s = S_IDLE;
      endcase

      case (state_s)
         S_IDLE:   tx_s = 1'b1;
         S_START:  tx_s = 1'b0;
         S_DATA:   tx_s = shift_s[0];
`ifdef CIPHER_TX_PARITY_EN
         S_PARITY: tx_s = par_s;
`endif
         S_STOP:   tx_s = 1'b1;
         default:  tx_s = 1'b1;
      endcase
   end

   // Sequencer registers; the line output is registered with the state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= S_IDLE;
         baud_r  <= BAUD_ZERO;
         bit_r   <= 3'd0;
         shift_r <= 8'h00;
         tx_r    <= 1'b1;
`ifdef CIPHER_TX_PARITY_EN
         par_r   <= 1'b0;
`endif
      end else begin
         state_r <= state_s;
         baud_r  <= baud_s;
         bit_r   <= bit_s;
         shift_r <= shift_s;
         tx_r    <= tx_s;
`ifdef CIPHER_TX_PARITY_EN
         par_r   <= par_s;
`endif
      end
   end

   // Completion: finished is latched, done is sticky until reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         seen_r <= 1'b0;
         done_r <= 1'b0;
      end else begin
         seen_r <= seen_r | bus.finished;
         done_r <= done_r | ((seen_r | bus.finished) & ~nonempty_s & (state_r == S_IDLE));
      end
   end

   assign bus.tx         = tx_r;
   assign bus.busy       = (state_r != S_IDLE);
   assign bus.done       = done_r;
   assign bus.overflow   = overflow_r;
   assign bus.fifo_count = count_r;

endmodule

// File: doc/cipher_uart_tx.md
# cipher_uart_tx

Downstream consumer of the XOR encryption stage. Captures each cipher byte presented on the encryptor's write strobe into a 16-entry FIFO and serialises the bytes out on an 8N1 UART line (optional parity), in write order. Signals completion once the encryptor reports `finished` and every captured byte has left the wire.

## Interface
Parameters:
- `CLKS_PER_BIT`, 868: clock cycles per UART bit (100 MHz / 115200); legal range ≥ 2.
- `DEPTH_LOG2`, 4: FIFO depth = 2^DEPTH_LOG2 entries.

Ports:
- `clk` in 1: single clock; all logic is rising-edge.
- `rst` in 1: reset, asynchronous and active-high.
- `cipher_w_en` in 1: write strobe from the encryptor; one byte per high cycle.
- `cipher_data` in 8: cipher byte, valid when `cipher_w_en`=1.
- `finished` in 1: encryptor completion level.
- `tx` out 1: UART serial line, idle high.
- `busy` out 1: high while a frame is on the wire.
- `done` out 1: sticky; high when finished, FIFO empty and line idle.
- `overflow` out 1: sticky; a byte was dropped because the FIFO was full.
- `fifo_count` out DEPTH_LOG2+1: current FIFO occupancy.

## Operation
- FIFO: write pointer, read pointer and count. Push when `cipher_w_en`=1 and not full. Pop only by the TX FSM.
- Push while full drops the byte and sets `overflow`. Exception: if a pop occurs in the same cycle, the push is accepted and count stays at 16.
- Push and pop in the same cycle at any occupancy leave the count unchanged. Pointers wrap modulo 2^DEPTH_LOG2.
- TX FSM states: IDLE, START, DATA, PARITY (macro only), STOP.
  - IDLE: `tx`=1. If count≠0, pop the head into the shift register, clear the bit counter and baud counter, and go to START.
  - START: `tx`=0 for CLKS_PER_BIT cycles, then DATA.
  - DATA: `tx`=shift[0], LSB first, each bit held CLKS_PER_BIT cycles. Shift right after each bit. After bit 7, go to PARITY if the macro is enabled, otherwise STOP.
  - PARITY: `tx`=XOR of the 8 data bits (even parity) for CLKS_PER_BIT cycles, then STOP.
  - STOP: `tx`=1 for CLKS_PER_BIT cycles. On the last cycle, if count≠0, pop and go straight to START (no idle gap); otherwise go to IDLE.
- Baud counter counts 0..CLKS_PER_BIT-1; the bit boundary is at the terminal count.
- `busy` = (state≠IDLE).
- `finished_seen` latches on `finished`=1 and stays set.
- `done` sets once `finished_seen`=1, count=0 and state=IDLE (including the cycle `finished` first rises, if those conditions already hold). It never clears except on `rst`.
- Bytes arriving after `done` are still captured and sent; `done` stays high.

## Timing
- Reset values: `tx`=1, `busy`=0, `done`=0, `overflow`=0, `fifo_count`=0. FSM in IDLE, pointers 0, `finished_seen`=0.
- `rst` mid-frame: `tx` returns high immediately (asynchronous). Buffered bytes are discarded. No partial frame resumes after reset release.
- Latency:
  - Byte pushed at edge k → count visible after edge k.
  - Pop and START entry at edge k+1 (if IDLE) → `tx` falls after edge k+1.
- Frame length: 10×CLKS_PER_BIT cycles, or 11×CLKS_PER_BIT with parity.
- Back-to-back frames are gap-free while the FIFO is non-empty.
- All outputs are registered except `busy` and `fifo_count`, which decode registered state directly.

## Configuration
- `CIPHER_TX_PARITY_EN` defined: PARITY state compiled in; frames are 8E1 (start, 8 data, even parity, stop).
- `CIPHER_TX_PARITY_EN` undefined: PARITY state and its logic absent; frames are 8N1.

## Test plan
- Single byte, CLKS_PER_BIT=4: push 0x41 → `tx` low 4 cycles, then 1,0,0,0,0,0,1,0 at 4 cycles each, then high 4 cycles; `busy` high for 40 cycles.
- Three consecutive pushes 0xA5, 0x3C, 0xFF → three frames in order with no idle cycle between STOP and the next START; `fifo_count` peaks at 2 (first byte popped immediately).
- 17 pushes in consecutive cycles while the line is busy → first 16 captured; `overflow`=1 on the 17th; only 16 frames emitted.
- Push 2 bytes, then raise `finished` during frame 1 → `done` stays 0 until the end of the second STOP, then 1 and held.
- Assert `rst` mid-DATA with 5 bytes queued → `tx`=1 immediately, `fifo_count`=0, `busy`=0, no frame after release.
- `CIPHER_TX_PARITY_EN` build, push 0x07 → parity bit 1 after data, frame 44 cycles at CLKS_PER_BIT=4; push 0x03 → parity bit 0.
